// File: rtl/lsq_issue_arbiter_pkg.sv
// Shared types and default tuning for the LSQ issue arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsq_issue_arbiter_pkg;

    // Which queue head(s) the issue port is presenting this cycle.
    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_STORE = 2'd2,
        SEL_FUSED = 2'd3
    } lsq_issue_sel_t;

    // Arbitration mode.
    typedef enum logic [1:0] {
        ARB_NORMAL      = 2'd0,
        ARB_STORE_BURST = 2'd1,
        ARB_DRAIN       = 2'd2
    } lsq_arb_state_t;

    // Cycles a ready store may lose before a forced burst is started.
    localparam int LSQ_STORE_STARVE_LIMIT = 8;
    // Maximum back-to-back stores once a burst starts.
    localparam int LSQ_STORE_BURST_LEN    = 4;

endpackage

// File: rtl/lsq_issue_arbiter.sv
// Picks load head, store head or fused pair for the LSQ issue port; generates pops.
// Latency: zero-cycle combinational grant when unlocked; drain_ack is registered (1 cycle).
// Backpressure: grant is latched while issue_valid & !issue_ready; pops only on handshake.
module lsq_issue_arbiter
    import lsq_issue_arbiter_pkg::*;
#(
    parameter int STORE_STARVE_LIMIT = LSQ_STORE_STARVE_LIMIT,
    parameter int STORE_BURST_LEN    = LSQ_STORE_BURST_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lq_valid,
    input  logic       lq_store_conflict,
    input  logic       lq_has_paired_store,
    input  logic       sq_valid,
    input  logic       sq_has_paired_load,
    input  logic       sq_full,
    input  logic       sq_empty,
    input  logic       drain_req,
    output logic       drain_ack,
    input  logic       issue_ready,
    output logic       issue_valid,
    output logic [1:0] issue_sel,
    output logic       lq_pop,
    output logic       sq_pop,
    output logic       tr_forced_store
);

    localparam int SW = $clog2(STORE_STARVE_LIMIT + 1);
    localparam int BW = $clog2(STORE_BURST_LEN + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STORE_STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(STORE_BURST_LEN);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    lsq_arb_state_t state_q, state_d, eff_state;
    lsq_issue_sel_t held_sel_q, grant;
    logic [SW-1:0]  starve_q, starve_d;
    logic [BW-1:0]  burst_q, burst_d, burst_inc;
    logic           lock_q, lock_d;
    logic           ack_q, ack_d;
    logic           load_c, store_c, fused_c;
    logic           forced, hs;

    assign load_c  = lq_valid & ~lq_store_conflict & ~lq_has_paired_store;
    assign store_c = sq_valid & ~sq_has_paired_load;
    assign fused_c = lq_valid & lq_has_paired_store & sq_valid & sq_has_paired_load;

    // Grant selection: the held grant while locked, otherwise per-mode priority.
    // A pending drain_req takes effect in the same unlocked cycle so no load slips out.
    always_comb begin
        grant     = SEL_NONE;
        forced    = 1'b0;
        eff_state = state_q;
        if (lock_q) begin
            grant = held_sel_q;
        end else begin
            if (drain_req)                  eff_state = ARB_DRAIN;
            else if (state_q == ARB_DRAIN)  eff_state = ARB_NORMAL;
            unique case (eff_state)
                ARB_STORE_BURST: begin
                    if (store_c)      grant = SEL_STORE;
                    else if (fused_c) grant = SEL_FUSED;
                    else if (load_c)  grant = SEL_LOAD;
                end
                ARB_DRAIN: begin
                    if (fused_c)      grant = SEL_FUSED;
                    else if (store_c) grant = SEL_STORE;
                end
                default: begin
                    if (store_c && ((starve_q == STARVE_MAX) || sq_full)) begin
                        grant  = SEL_STORE;
                        forced = 1'b1;
                    end else if (fused_c) grant = SEL_FUSED;
                    else if (load_c)      grant = SEL_LOAD;
                    else if (store_c)     grant = SEL_STORE;
                end
            endcase
        end
        // Nothing is presented while reset is held.
        if (!rst) begin
            grant  = SEL_NONE;
            forced = 1'b0;
        end
    end

    assign issue_valid     = (grant != SEL_NONE);
    assign issue_sel       = grant;
    assign hs              = issue_valid & issue_ready;
    assign lq_pop          = hs & ((grant == SEL_LOAD)  | (grant == SEL_FUSED));
    assign sq_pop          = hs & ((grant == SEL_STORE) | (grant == SEL_FUSED));
    assign tr_forced_store = forced;
    assign drain_ack       = ack_q & drain_req & rst;
    assign burst_inc       = burst_q + BURST_ONE;

    // Mode transitions, burst counting, starvation counting, lock and drain-ack next state.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        starve_d = starve_q;
        lock_d   = issue_valid & ~issue_ready;
        ack_d    = ~lock_q & drain_req & sq_empty & ~fused_c;

        // Starvation: a store handshake always clears; otherwise frozen while locked.
        if (hs && (grant == SEL_STORE)) begin
            starve_d = '0;
        end else if (!lock_q) begin
            if (!store_c)                starve_d = '0;
            else if (grant != SEL_STORE) starve_d = (starve_q == STARVE_MAX) ? starve_q
                                                                             : starve_q + SW'(1);
        end

        if (lock_q) begin
            if ((state_q == ARB_DRAIN) && !drain_req) begin
                state_d = ARB_NORMAL;
            end else if ((state_q == ARB_STORE_BURST) && hs && (grant == SEL_STORE)) begin
                if (burst_inc == BURST_MAX) begin
                    state_d = ARB_NORMAL;
                    burst_d = '0;
                end else begin
                    burst_d = burst_inc;
                end
            end
        end else if (drain_req) begin
            state_d = ARB_DRAIN;
            burst_d = '0;
        end else if (eff_state == ARB_STORE_BURST) begin
            if (!store_c) begin
                state_d = ARB_NORMAL;
                burst_d = '0;
            end else if (hs) begin
                if (burst_inc == BURST_MAX) begin
                    state_d = ARB_NORMAL;
                    burst_d = '0;
                end else begin
                    burst_d = burst_inc;
                end
            end
        end else begin
            // Normal mode (including the cycle that leaves drain).
            state_d = ARB_NORMAL;
            burst_d = '0;
            if (forced) begin
                // A one-store burst that completes on its first handshake never stays in burst mode.
                if (hs && (BURST_ONE == BURST_MAX)) begin
                    state_d = ARB_NORMAL;
                end else begin
                    state_d = ARB_STORE_BURST;
                    burst_d = hs ? BURST_ONE : '0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset; reset drops any held grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_NORMAL;
            starve_q   <= '0;
            burst_q    <= '0;
            lock_q     <= 1'b0;
            held_sel_q <= SEL_NONE;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            lock_q     <= lock_d;
            held_sel_q <= grant;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Self-checking bench for lsq_issue_arbiter: directed scenarios plus random traffic.
// Latency: outputs compared each cycle against a cycle-level reference model.
// Backpressure: issue_ready is driven randomly to exercise grant holding.
module tb_lsq_issue_arbiter;

    localparam int LIMIT = 8;
    localparam int BLEN  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       lq_valid, lq_store_conflict, lq_has_paired_store;
    logic       sq_valid, sq_has_paired_load, sq_full, sq_empty;
    logic       drain_req, issue_ready;
    logic       drain_ack, issue_valid, lq_pop, sq_pop, tr_forced_store;
    logic [1:0] issue_sel;

    always #5 clk = ~clk;

    lsq_issue_arbiter #(
        .STORE_STARVE_LIMIT(LIMIT),
        .STORE_BURST_LEN   (BLEN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lq_valid           (lq_valid),
        .lq_store_conflict  (lq_store_conflict),
        .lq_has_paired_store(lq_has_paired_store),
        .sq_valid           (sq_valid),
        .sq_has_paired_load (sq_has_paired_load),
        .sq_full            (sq_full),
        .sq_empty           (sq_empty),
        .drain_req          (drain_req),
        .drain_ack          (drain_ack),
        .issue_ready        (issue_ready),
        .issue_valid        (issue_valid),
        .issue_sel          (issue_sel),
        .lq_pop             (lq_pop),
        .sq_pop             (sq_pop),
        .tr_forced_store    (tr_forced_store)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=normal 1=burst 2=drain; sel 0=none 1=load 2=store 3=fused.
    int m_mode = 0, m_starve = 0, m_burst = 0, m_held = 0;
    bit m_lock = 0, m_ack = 0;
    int e_sel, e_mode;
    bit e_tr, e_hs, e_ack, e_lc, e_sc, e_fc;
    int s_sel;
    bit s_valid, s_lqpop, s_sqpop, s_tr, s_ack;

    task automatic model_eval();
        e_lc   = lq_valid && !lq_store_conflict && !lq_has_paired_store;
        e_sc   = sq_valid && !sq_has_paired_load;
        e_fc   = lq_valid && lq_has_paired_store && sq_valid && sq_has_paired_load;
        e_sel  = 0;
        e_tr   = 0;
        e_mode = m_mode;
        if (rst && m_lock) begin
            e_sel = m_held;
        end else if (rst) begin
            e_mode = drain_req ? 2 : ((m_mode == 2) ? 0 : m_mode);
            if (e_mode == 0) begin
                if (e_sc && (m_starve == LIMIT || sq_full)) begin
                    e_sel = 2;
                    e_tr  = 1;
                end else if (e_fc) e_sel = 3;
                else if (e_lc)     e_sel = 1;
                else if (e_sc)     e_sel = 2;
            end else if (e_mode == 1) begin
                if (e_sc)      e_sel = 2;
                else if (e_fc) e_sel = 3;
                else if (e_lc) e_sel = 1;
            end else begin
                if (e_fc)      e_sel = 3;
                else if (e_sc) e_sel = 2;
            end
        end
        e_hs  = (e_sel != 0) && issue_ready;
        e_ack = rst && m_ack && drain_req;
    endtask

    task automatic model_commit();
        bit new_ack;
        if (!rst) begin
            m_mode = 0; m_starve = 0; m_burst = 0; m_held = 0; m_lock = 0; m_ack = 0;
        end else begin
            new_ack = !m_lock && drain_req && sq_empty && !e_fc;
            if (e_hs && e_sel == 2) m_starve = 0;
            else if (!m_lock) begin
                if (!e_sc)            m_starve = 0;
                else if (e_sel != 2)  m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            end
            if (m_lock) begin
                if (m_mode == 2 && !drain_req) m_mode = 0;
                else if (m_mode == 1 && e_hs && e_sel == 2) begin
                    m_burst++;
                    if (m_burst == BLEN) begin m_mode = 0; m_burst = 0; end
                end
            end else if (drain_req) begin
                m_mode = 2; m_burst = 0;
            end else if (e_mode == 1) begin
                if (!e_sc) begin m_mode = 0; m_burst = 0; end
                else if (e_hs) begin
                    m_burst++;
                    if (m_burst == BLEN) begin m_mode = 0; m_burst = 0; end
                end
            end else if (e_tr) begin
                m_mode  = 1;
                m_burst = e_hs ? 1 : 0;
                if (m_burst == BLEN) begin m_mode = 0; m_burst = 0; end
            end else begin
                m_mode = 0; m_burst = 0;
            end
            m_lock = (e_sel != 0) && !issue_ready;
            m_held = e_sel;
            m_ack  = new_ack;
        end
    endtask

    // One cycle: compare settled outputs with the model, then clock both.
    task automatic step(input string ph);
        #1;
        model_eval();
        s_sel   = int'(issue_sel);
        s_valid = issue_valid;
        s_lqpop = lq_pop;
        s_sqpop = sq_pop;
        s_tr    = tr_forced_store;
        s_ack   = drain_ack;
        chk({ph, ".sel"},   s_sel,        e_sel);
        chk({ph, ".valid"}, int'(s_valid), int'(e_sel != 0));
        chk({ph, ".lqpop"}, int'(s_lqpop), int'(e_hs && (e_sel == 1 || e_sel == 3)));
        chk({ph, ".sqpop"}, int'(s_sqpop), int'(e_hs && (e_sel == 2 || e_sel == 3)));
        chk({ph, ".tr"},    int'(s_tr),    int'(e_tr));
        chk({ph, ".ack"},   int'(s_ack),   int'(e_ack));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_in(input bit lv, input bit cf, input bit lps, input bit sv, input bit spl,
                          input bit full, input bit empty, input bit dr, input bit rdy);
        lq_valid = lv; lq_store_conflict = cf; lq_has_paired_store = lps;
        sq_valid = sv; sq_has_paired_load = spl; sq_full = full; sq_empty = empty;
        drain_req = dr; issue_ready = rdy;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rst");
        step("rst");
        rst = 1'b1;
        step("idle");
        chk("idle_valid", int'(s_valid), 0);

        // Loads win for LIMIT cycles, then a forced burst of BLEN stores, then loads again.
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            step("starve");
            chk("starve_seq", s_sel, (i >= LIMIT && i < LIMIT + BLEN) ? 2 : 1);
            if (i == LIMIT) chk("starve_tr", int'(s_tr), 1);
        end

        // Full store queue forces a store immediately.
        set_in(1, 0, 0, 1, 0, 1, 0, 0, 1);
        step("full");
        chk("full_sel", s_sel, 2);
        chk("full_tr", int'(s_tr), 1);
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 1);
        step("full");
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("clr");
        step("clr");

        // Load held under backpressure while a conflict appears.
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step("hold");
        chk("hold_sel0", s_sel, 1);
        lq_store_conflict = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step("hold");
            chk("hold_sel", s_sel, 1);
            chk("hold_nopop", int'(s_lqpop), 0);
        end
        issue_ready = 1'b1;
        step("hold");
        chk("hold_pop", int'(s_lqpop), 1);

        // Fused pair, then a one-sided pair that must wait.
        set_in(1, 0, 1, 1, 1, 0, 0, 0, 1);
        step("fused");
        chk("fused_sel", s_sel, 3);
        chk("fused_pops", int'(s_lqpop) + int'(s_sqpop), 2);
        set_in(1, 0, 1, 0, 0, 0, 1, 0, 1);
        step("half");
        chk("half_valid", int'(s_valid), 0);

        // Drain: two stores, no loads, ack the cycle after the queue empties, then release.
        set_in(1, 0, 0, 1, 0, 0, 0, 1, 1);
        step("drain");
        chk("drain_st0", s_sel, 2);
        step("drain");
        chk("drain_st1", s_sel, 2);
        set_in(1, 0, 0, 0, 0, 0, 1, 1, 1);
        step("drain");
        chk("drain_noload", s_sel, 0);
        chk("drain_ack0", int'(s_ack), 0);
        step("drain");
        chk("drain_ack1", int'(s_ack), 1);
        drain_req = 1'b0;
        step("undrain");
        chk("undrain_ack", int'(s_ack), 0);
        chk("undrain_sel", s_sel, 1);

        // Reset while locked on a store discards the held grant.
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("rlock");
        chk("rlock_sel", s_sel, 2);
        rst = 1'b0;
        issue_ready = 1'b1;
        step("rlock");
        chk("rlock_pop", int'(s_sqpop), 0);
        chk("rlock_valid", int'(s_valid), 0);
        rst = 1'b1;
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step("rlock");
        chk("rlock_after", s_sel, 1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst                 = ($urandom_range(0, 199) != 0);
            lq_valid            = ($urandom_range(0, 3) != 0);
            lq_store_conflict   = ($urandom_range(0, 4) == 0);
            lq_has_paired_store = ($urandom_range(0, 5) == 0);
            sq_valid            = ($urandom_range(0, 2) != 0);
            sq_has_paired_load  = lq_has_paired_store ? ($urandom_range(0, 1) == 0)
                                                      : ($urandom_range(0, 7) == 0);
            sq_full             = ($urandom_range(0, 9) == 0);
            sq_empty            = !sq_valid && ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 29) == 0) drain_req = !drain_req;
            issue_ready         = ($urandom_range(0, 3) != 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
